// File: rtl/exe_stage_hs_pkg.sv
// Shared definitions for the execute stage: store/target codes, MCU FSM
// state encoding, memory field widths and the alignment helper.
package exe_stage_hs_pkg;

  localparam int MEM_TRANSFER_W = 2;
  localparam int MEM_LOAD_W     = 3;

  // Store size codes (match RISC-V store funct3[1:0])
  localparam logic [MEM_TRANSFER_W-1:0] STORE_SB = 2'd0;
  localparam logic [MEM_TRANSFER_W-1:0] STORE_SH = 2'd1;
  localparam logic [MEM_TRANSFER_W-1:0] STORE_SW = 2'd2;

  // Writeback value selection
  localparam logic [1:0] TGT_RES   = 2'd0;
  localparam logic [1:0] TGT_STORE = 2'd1;
  localparam logic [1:0] TGT_ZERO  = 2'd2;
  localparam logic [1:0] TGT_LINK  = 2'd3;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_ISSUE = 3'd1,
    MC_WAIT  = 3'd2,
    MC_DONE  = 3'd3,
    MC_DRAIN = 3'd4
  } mc_state_e;

  // size: 0 byte, 1 half, 2 word; only the two low address bits matter
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    return ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr != 2'd0));
  endfunction

endpackage

// File: rtl/exe_stage_hs_if.sv
// Decode-side, memory-side, ALU and MCU signals of the execute stage.
// slave: the execute stage itself; master: its environment.
interface exe_stage_hs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 5
);
  import exe_stage_hs_pkg::*;

  // decode side
  logic                      e_valid_i;
  logic                      e_ready_o;
  logic [ALU_OP_W-1:0]       e_alu_op_i;
  logic [1:0]                e_data_origin_i;
  logic [1:0]                e_data_target_i;
  logic [MEM_TRANSFER_W-1:0] e_store_op_i;
  logic [MEM_LOAD_W-1:0]     e_load_op_i;
  logic [DATA_WIDTH-1:0]     e_rs1_i;
  logic [DATA_WIDTH-1:0]     e_rs2_i;
  logic [DATA_WIDTH-1:0]     e_imm_i;
  logic [DATA_WIDTH-1:0]     e_pc4_i;
  logic [DATA_WIDTH-1:0]     e_brj_pc_i;
  logic [REG_ADDR_W-1:0]     e_waddr_i;
  logic                      e_regfile_wr_i;
  logic                      e_data_rd_i;
  logic                      e_data_wr_i;
  // external ALU
  logic [DATA_WIDTH-1:0]     alu_op1_o;
  logic [DATA_WIDTH-1:0]     alu_op2_o;
  logic [DATA_WIDTH-1:0]     alu_res_i;
  // multi-cycle unit
  logic                      mc_req_o;
  logic                      mc_ack_i;
  logic                      mc_done_i;
  logic [DATA_WIDTH-1:0]     mc_res_i;
  // memory side
  logic                      m_valid_o;
  logic                      m_ready_i;
  logic [REG_ADDR_W-1:0]     m_waddr_o;
  logic [DATA_WIDTH-1:0]     m_rd_o;
  logic                      m_regfile_wr_o;
  logic                      m_data_rd_o;
  logic                      m_data_wr_o;
  logic [DATA_WIDTH-1:0]     m_data_addr_o;
  logic [MEM_LOAD_W-1:0]     m_load_op_o;
  logic                      m_misalign_o;

  modport slave (
    input  e_valid_i, e_alu_op_i, e_data_origin_i, e_data_target_i, e_store_op_i,
           e_load_op_i, e_rs1_i, e_rs2_i, e_imm_i, e_pc4_i, e_brj_pc_i, e_waddr_i,
           e_regfile_wr_i, e_data_rd_i, e_data_wr_i,
           alu_res_i, mc_ack_i, mc_done_i, mc_res_i, m_ready_i,
    output e_ready_o, alu_op1_o, alu_op2_o, mc_req_o,
           m_valid_o, m_waddr_o, m_rd_o, m_regfile_wr_o, m_data_rd_o, m_data_wr_o,
           m_data_addr_o, m_load_op_o, m_misalign_o
  );

  modport master (
    output e_valid_i, e_alu_op_i, e_data_origin_i, e_data_target_i, e_store_op_i,
           e_load_op_i, e_rs1_i, e_rs2_i, e_imm_i, e_pc4_i, e_brj_pc_i, e_waddr_i,
           e_regfile_wr_i, e_data_rd_i, e_data_wr_i,
           alu_res_i, mc_ack_i, mc_done_i, mc_res_i, m_ready_i,
    input  e_ready_o, alu_op1_o, alu_op2_o, mc_req_o,
           m_valid_o, m_waddr_o, m_rd_o, m_regfile_wr_o, m_data_rd_o, m_data_wr_o,
           m_data_addr_o, m_load_op_o, m_misalign_o
  );

endinterface

// File: rtl/exe_mc_ctrl.sv
// MCU issue controller: one request per MCU op, result capture, and the
// decode-side ready. A flushed op still in the MCU is drained (its done
// pulse is swallowed) before anything new is accepted.
module exe_mc_ctrl
  import exe_stage_hs_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  e_valid_i,
  input  logic                  is_mc_i,
  input  logic                  slot_free_i,
  input  logic                  mc_ack_i,
  input  logic                  mc_done_i,
  input  logic [DATA_WIDTH-1:0] mc_res_i,
  output logic                  mc_req_o,
  output logic                  e_ready_o,
  output logic                  use_mc_res_o,
  output logic [DATA_WIDTH-1:0] mc_res_q_o
);

  mc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;

  // state and captured MCU result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MC_IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  // next state, request and ready
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    mc_req_o  = 1'b0;
    e_ready_o = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (!flush_i && e_valid_i) begin
          if (is_mc_i) state_d   = MC_ISSUE;
          else         e_ready_o = slot_free_i;
        end
      end
      MC_ISSUE: begin
        mc_req_o = 1'b1;
        if (mc_ack_i) begin
          if (mc_done_i) begin
            // op finished in the accept cycle: nothing left to drain
            if (flush_i) state_d = MC_IDLE;
            else begin
              res_d   = mc_res_i;
              state_d = MC_DONE;
            end
          end else begin
            state_d = flush_i ? MC_DRAIN : MC_WAIT;
          end
        end else if (flush_i) begin
          state_d = MC_IDLE;
        end
      end
      MC_WAIT: begin
        if (mc_done_i) begin
          if (flush_i) state_d = MC_IDLE;
          else begin
            res_d   = mc_res_i;
            state_d = MC_DONE;
          end
        end else if (flush_i) begin
          state_d = MC_DRAIN;
        end
      end
      MC_DONE: begin
        if (flush_i) state_d = MC_IDLE;
        else begin
          e_ready_o = slot_free_i;
          if (e_valid_i && slot_free_i) state_d = MC_IDLE;
        end
      end
      MC_DRAIN: begin
        if (mc_done_i) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  assign use_mc_res_o = (state_q == MC_DONE);
  assign mc_res_q_o   = res_q;

endmodule

// File: rtl/exe_stage_hs.sv
// Execute stage with valid/ready flow control. Selects ALU operands, muxes
// the writeback value, builds store data and owns the EX/MEM register.
// Optional: EXE_MISALIGN_CHK_EN adds a misaligned-access flag that also
// suppresses the memory and register-file writes of the faulting access.
module exe_stage_hs
  import exe_stage_hs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 5
) (
  input logic          clk,
  input logic          rst,
  input logic          flush_i,
  exe_stage_hs_if.slave bus
);

  logic                  e_ready, accept, slot_free, use_mc_res, mis;
  logic [DATA_WIDTH-1:0] mc_res_q, exe_res, store_data, link_val, wb_val;

  logic                      m_valid_q, m_regfile_wr_q, m_data_rd_q, m_data_wr_q, m_misalign_q;
  logic [REG_ADDR_W-1:0]     m_waddr_q;
  logic [DATA_WIDTH-1:0]     m_rd_q, m_data_addr_q;
  logic [MEM_LOAD_W-1:0]     m_load_op_q;

  assign slot_free = !m_valid_q || bus.m_ready_i;
  assign accept    = bus.e_valid_i && e_ready;

  exe_mc_ctrl #(.DATA_WIDTH(DATA_WIDTH)) u_mc_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .e_valid_i    (bus.e_valid_i),
    .is_mc_i      (bus.e_alu_op_i[ALU_OP_W-1]),
    .slot_free_i  (slot_free),
    .mc_ack_i     (bus.mc_ack_i),
    .mc_done_i    (bus.mc_done_i),
    .mc_res_i     (bus.mc_res_i),
    .mc_req_o     (bus.mc_req_o),
    .e_ready_o    (e_ready),
    .use_mc_res_o (use_mc_res),
    .mc_res_q_o   (mc_res_q)
  );

  assign bus.e_ready_o = e_ready;
  assign bus.alu_op1_o = bus.e_rs1_i;
  assign bus.alu_op2_o = bus.e_data_origin_i[0] ? bus.e_imm_i : bus.e_rs2_i;

  assign exe_res  = use_mc_res ? mc_res_q : bus.alu_res_i;
  assign link_val = bus.e_data_origin_i[1] ? bus.e_pc4_i : bus.e_brj_pc_i;

  // store data, zero-extended to the datapath width
  always_comb begin
    store_data = bus.e_rs2_i;
    case (bus.e_store_op_i)
      STORE_SB: store_data = {{(DATA_WIDTH-8){1'b0}},  bus.e_rs2_i[7:0]};
      STORE_SH: store_data = {{(DATA_WIDTH-16){1'b0}}, bus.e_rs2_i[15:0]};
      default:  store_data = bus.e_rs2_i;
    endcase
  end

  // writeback value select
  always_comb begin
    wb_val = exe_res;
    case (bus.e_data_target_i)
      TGT_RES:   wb_val = exe_res;
      TGT_STORE: wb_val = store_data;
      TGT_ZERO:  wb_val = '0;
      TGT_LINK:  wb_val = link_val;
      default:   wb_val = exe_res;
    endcase
  end

`ifdef EXE_MISALIGN_CHK_EN
  assign mis = (bus.e_data_rd_i && misaligned(bus.e_load_op_i[1:0], exe_res[1:0])) ||
               (bus.e_data_wr_i && misaligned(bus.e_store_op_i, exe_res[1:0]));
`else
  assign mis = 1'b0;
`endif

  // EX/MEM register: load on accept, drain when memory consumes, kill on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q      <= 1'b0;
      m_waddr_q      <= '0;
      m_rd_q         <= '0;
      m_regfile_wr_q <= 1'b0;
      m_data_rd_q    <= 1'b0;
      m_data_wr_q    <= 1'b0;
      m_data_addr_q  <= '0;
      m_load_op_q    <= '0;
      m_misalign_q   <= 1'b0;
    end else if (flush_i) begin
      m_valid_q <= 1'b0;
    end else if (accept) begin
      m_valid_q      <= 1'b1;
      m_waddr_q      <= bus.e_waddr_i;
      m_rd_q         <= wb_val;
      m_regfile_wr_q <= bus.e_regfile_wr_i && !mis;
      m_data_rd_q    <= bus.e_data_rd_i && !mis;
      m_data_wr_q    <= bus.e_data_wr_i && !mis;
      m_data_addr_q  <= exe_res;
      m_load_op_q    <= bus.e_load_op_i;
      m_misalign_q   <= mis;
    end else if (bus.m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_valid_o      = m_valid_q;
  assign bus.m_waddr_o      = m_waddr_q;
  assign bus.m_rd_o         = m_rd_q;
  assign bus.m_regfile_wr_o = m_regfile_wr_q;
  assign bus.m_data_rd_o    = m_data_rd_q;
  assign bus.m_data_wr_o    = m_data_wr_q;
  assign bus.m_data_addr_o  = m_data_addr_q;
  assign bus.m_load_op_o    = m_load_op_q;
  assign bus.m_misalign_o   = m_misalign_q;

endmodule
